// File: rtl/conv_5x5_mac.sv
// 5x5 convolution MAC: 3-stage multiply / adder-tree pipeline behind the line buffer.
// Optional ReLU on the result is enabled by defining CONV_RELU_EN.
module conv_5x5_mac #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int K     = 5,
   parameter int DW    = 16
) (
   input  logic                   CLK,
   input  logic                   reset,
   input  logic                   Valid,
   input  logic [K*K*DW-1:0]      window_flat,
   input  logic                   w_load,
   input  logic signed [DW-1:0]   w_data,
   output logic signed [31:0]     data_out,
   output logic                   out_valid,
   output logic                   invalid,
   output logic                   packet_done
);

   localparam int NT  = K * K;
   localparam int PW  = 2 * DW;
   localparam int RSW = PW + 3;
   localparam int SW  = PW + 6;
   localparam int CW  = $clog2(IMG_W);
   localparam int RW  = $clog2(IMG_H);
   localparam int IW  = $clog2(NT);

   localparam logic signed [SW-1:0] SMAX = SW'(64'sd2147483647);
   localparam logic signed [SW-1:0] SMIN = SW'(-64'sd2147483648);

   logic [CW-1:0]          col_q, col_d;
   logic [RW-1:0]          row_q, row_d;
   logic [IW-1:0]          widx_q, widx_d;
   logic signed [DW-1:0]   w_q [NT];

   logic signed [PW-1:0]   prod_d [NT];
   logic signed [PW-1:0]   prod_q [NT];
   logic signed [RSW-1:0]  rsum_d [K];
   logic signed [RSW-1:0]  rsum_q [K];
   logic signed [SW-1:0]   sum_d;
   logic signed [31:0]     res_d;

   logic legal, col_end, row_end;
   logic v1_q, i1_q, e1_q;
   logic v2_q, i2_q, e2_q;

   // Window position decode for the pixel arriving this cycle
   always_comb begin
      col_end = (col_q == CW'(IMG_W - 1));
      row_end = (row_q == RW'(IMG_H - 1));
      legal   = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
   end

   // Raster counters and weight index next-state
   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      widx_d = widx_q;
      if (Valid) begin
         if (col_end) begin
            col_d = '0;
            row_d = row_end ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
      if (w_load) begin
         widx_d = (widx_q == IW'(NT - 1)) ? '0 : widx_q + 1'b1;
      end
   end

   // Counter, index and weight storage
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         col_q  <= '0;
         row_q  <= '0;
         widx_q <= '0;
         for (int i = 0; i < NT; i++) w_q[i] <= '0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         widx_q <= widx_d;
         for (int i = 0; i < NT; i++) begin
            if (w_load && (widx_q == IW'(i))) w_q[i] <= w_data;
         end
      end
   end

   // S1 products and S2 row sums (combinational parts)
   always_comb begin
      for (int i = 0; i < NT; i++) begin
         prod_d[i] = PW'($signed(window_flat[DW*i +: DW])) * PW'(w_q[i]);
      end
      for (int r = 0; r < K; r++) begin
         rsum_d[r] = '0;
         for (int c = 0; c < K; c++) begin
            rsum_d[r] = rsum_d[r] + RSW'(prod_q[K*r + c]);
         end
      end
   end

   // S3 final sum, saturation and optional rectification
   always_comb begin
      sum_d = '0;
      for (int r = 0; r < K; r++) sum_d = sum_d + SW'(rsum_q[r]);
      if (sum_d > SMAX)      res_d = 32'sh7FFF_FFFF;
      else if (sum_d < SMIN) res_d = 32'sh8000_0000;
      else                   res_d = sum_d[31:0];
`ifdef CONV_RELU_EN
      if (res_d[31]) res_d = '0;
`else
      res_d = res_d;
`endif
   end

   // Pipeline registers: data plus valid/illegal/frame-end tags
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NT; i++) prod_q[i] <= '0;
         for (int r = 0; r < K; r++) rsum_q[r] <= '0;
         v1_q        <= 1'b0;
         i1_q        <= 1'b0;
         e1_q        <= 1'b0;
         v2_q        <= 1'b0;
         i2_q        <= 1'b0;
         e2_q        <= 1'b0;
         out_valid   <= 1'b0;
         invalid     <= 1'b0;
         packet_done <= 1'b0;
         data_out    <= '0;
      end else begin
         for (int i = 0; i < NT; i++) prod_q[i] <= prod_d[i];
         for (int r = 0; r < K; r++) rsum_q[r] <= rsum_d[r];
         v1_q        <= Valid & legal;
         i1_q        <= Valid & ~legal;
         e1_q        <= Valid & col_end & row_end;
         v2_q        <= v1_q;
         i2_q        <= i1_q;
         e2_q        <= e1_q;
         out_valid   <= v2_q;
         invalid     <= i2_q;
         packet_done <= e2_q;
         if (v2_q) data_out <= res_d;
      end
   end

endmodule
